// File: rtl/result_drain.sv
// Drains rows of the result BRAM onto a one-lane-per-beat valid/ready stream.
// One row is read per ISSUE/CAPTURE pair and emitted lane 0 first.
module result_drain #(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH:0]            num_rows,
  output logic                           busy,
  output logic                           done,
  output logic                           bram_r_rd_en,
  output logic [ADDR_WIDTH-1:0]          bram_r_rd_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_dout,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast
);

  localparam int LANE_W = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
  localparam int CNT_W  = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] row_ptr, row_ptr_next;
  logic [CNT_W-1:0]      remaining, remaining_next;
  logic [LANE_W-1:0]     lane, lane_next;
  logic [DATA_WIDTH-1:0] row_buf [PE_COUNT];
  logic                  capture_en;
  logic                  last_lane;
  logic                  last_row;
  logic [ADDR_WIDTH-1:0] row_ptr_inc;

  assign last_lane      = (lane == LANE_W'(PE_COUNT - 1));
  assign last_row       = (remaining == CNT_W'(1));
  assign bram_r_rd_addr = row_ptr;

  // Explicit wrap keeps non-power-of-two depths correct.
  assign row_ptr_inc = (row_ptr == ADDR_WIDTH'(BRAM_DEPTH - 1)) ? '0
                                                                : row_ptr + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      row_ptr   <= '0;
      remaining <= '0;
      lane      <= '0;
    end else begin
      state     <= state_next;
      row_ptr   <= row_ptr_next;
      remaining <= remaining_next;
      lane      <= lane_next;
    end
  end

  // The row buffer is loaded once per row, so a stalled beat never re-reads the BRAM.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < PE_COUNT; i++) begin
        row_buf[i] <= '0;
      end
    end else if (capture_en) begin
      for (int i = 0; i < PE_COUNT; i++) begin
        row_buf[i] <= bram_r_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_next     = state;
    row_ptr_next   = row_ptr;
    remaining_next = remaining;
    lane_next      = lane;
    capture_en     = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    bram_r_rd_en   = 1'b0;
    m_tvalid       = 1'b0;
    m_tlast        = 1'b0;
    m_tdata        = '0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (num_rows != '0) begin
            row_ptr_next   = base_addr;
            remaining_next = num_rows;
            state_next     = S_ISSUE;
          end else begin
            state_next = S_DONE;
          end
        end
      end

      S_ISSUE: begin
        bram_r_rd_en = 1'b1;
        state_next   = S_CAPTURE;
      end

      S_CAPTURE: begin
        capture_en = 1'b1;
        lane_next  = '0;
        state_next = S_EMIT;
      end

      S_EMIT: begin
        m_tvalid = 1'b1;
        m_tdata  = row_buf[lane];
        m_tlast  = last_lane && last_row;
        if (m_tready) begin
          if (last_lane) begin
            remaining_next = remaining - CNT_W'(1);
            row_ptr_next   = row_ptr_inc;
            lane_next      = '0;
            state_next     = last_row ? S_DONE : S_ISSUE;
          end else begin
            lane_next = lane + LANE_W'(1);
          end
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
